// File: rtl/uart_rx_pkg.sv
// Shared encodings and constants for the 16x-oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic [3:0] SAMP_A  = 4'd7;
    localparam logic [3:0] SAMP_B  = 4'd8;
    localparam logic [3:0] SAMP_C  = 4'd9;
    localparam logic [3:0] BIT_END = 4'd15;

    localparam int unsigned DATA_BITS = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty=0.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the head slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority per bit, FWFT receive
// FIFO with edge-detected pop, sticky framing-error and overrun flags.
module uart_rx_os16
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baudclk16,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       ready,
    input  logic       read_strobe,
    input  logic       clear_err,
    output logic       frame_err,
    output logic       overrun
);

    rx_state_t             state;
    logic                  rxd_meta;
    logic                  rxd_sync;
    logic [3:0]            cnt;
    logic [2:0]            bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  samp_a;
    logic                  samp_b;
    logic                  rs_prev;

    logic                  maj;
    logic                  pop;
    logic                  stop_decide;
    logic                  push_req;
    logic                  fe_set;
    logic                  ovr_set;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign maj         = majority3(samp_a, samp_b, rxd_sync);
    assign pop         = read_strobe && !rs_prev;
    assign stop_decide = baudclk16 && (state == STOP) && (cnt == SAMP_C);
    assign push_req    = stop_decide && maj;
    assign fe_set      = stop_decide && !maj;
    assign ovr_set     = push_req && fifo_full && !pop;
    assign ready       = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .DW    (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg),
        .pop       (pop),
        .head      (data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            rs_prev   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rs_prev  <= read_strobe;

            // Set events take priority over a coincident clear.
            if (fe_set)         frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
            if (ovr_set)        overrun   <= 1'b1;
            else if (clear_err) overrun   <= 1'b0;

            if (baudclk16) begin
                if (cnt == SAMP_A) samp_a <= rxd_sync;
                if (cnt == SAMP_B) samp_b <= rxd_sync;

                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rxd_sync) state <= START;
                    end
                    START: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == SAMP_C && maj) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == BIT_END) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == SAMP_C) shreg <= {maj, shreg[DATA_BITS-1:1]};
                        if (cnt == BIT_END) begin
                            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
                            else                               bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    STOP: begin
                        cnt <= cnt + 4'd1;
                        // Leave mid-stop-bit so the next start edge is not missed.
                        if (cnt == SAMP_C) begin
                            cnt   <= '0;
                            state <= maj ? IDLE : WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        cnt <= '0;
                        if (rxd_sync) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: frames are driven bit by bit, expected
// bytes are queued at send time and checked by a monitor on each pop edge.
module tb_uart_rx_os16;

    logic       clk = 1'b0;
    logic       reset;
    logic       baudclk16;
    logic       rxd;
    logic       read_strobe;
    logic       clear_err;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    logic [1:0] tcnt = '0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic       mon_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign baudclk16 = (tcnt == 2'd3);

    uart_rx_os16 #(
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baudclk16   (baudclk16),
        .rxd         (rxd),
        .data        (data),
        .ready       (ready),
        .read_strobe (read_strobe),
        .clear_err   (clear_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens on the next posedge when read_strobe rises.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (read_strobe && !mon_prev && ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_unexpected: got %02h expected none", data);
                end else begin
                    check("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
            end
            mon_prev = read_strobe;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Start edge is driven on the negedge right after a baud tick, so the
    // stop-bit decision tick lands on the 620th posedge after it.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit chk_lat,
                              input int pop_at, input int abort_at);
        do @(negedge clk); while (tcnt != 2'd0);
        rxd = 1'b0;
        for (int k = 1; k <= 640; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                reset = 1'b1;
                rxd   = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (k % 64 == 0) begin
                if (k < 576)       rxd = b[k/64 - 1];
                else if (k == 576) rxd = stop_b;
            end
            if (pop_at != 0 && k == pop_at)     read_strobe = 1'b1;
            if (pop_at != 0 && k == pop_at + 2) read_strobe = 1'b0;
            if (chk_lat && k == 619) check("ready_before_push", ready, 0);
            if (chk_lat && k == 620) begin
                check("ready_after_push", ready, 1);
                check("data_after_push", {24'd0, data}, {24'd0, b});
            end
        end
    endtask

    task automatic pop_one();
        int w = 0;
        @(negedge clk);
        while (!ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            check("pop_wait_ready", ready, 1);
            return;
        end
        read_strobe = 1'b1;
        repeat (2) @(negedge clk);
        read_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        rxd         = 1'b1;
        read_strobe = 1'b0;
        clear_err   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_data", {24'd0, data}, 32'h0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Single byte, latency and held read_strobe.
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b1, 0, 0);
        pop_one();
        check("t1_ready_after_pop", ready, 0);
        check("t1_queue_drained", exp_q.size(), 0);

        // Start-bit glitch rejected.
        do @(negedge clk); while (tcnt != 2'd0);
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("t2_ready", ready, 0);
        check("t2_frame_err", frame_err, 0);

        // Framing error followed by a break, then a good byte.
        send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
        repeat (160) @(negedge clk);
        rxd = 1'b1;
        repeat (64) @(negedge clk);
        check("t3_frame_err_set", frame_err, 1);
        check("t3_bad_not_stored", ready, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
        check("t3_frame_err_sticky", frame_err, 1);
        check("t3_overrun", overrun, 0);
        pop_one();
        check("t3_ready_after_pop", ready, 0);
        pulse_clear();
        check("t3_frame_err_cleared", frame_err, 0);

        // Overrun on the fifth unread byte.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0, 0, 0);
        end
        check("t4_overrun_set", overrun, 1);
        check("t4_frame_err", frame_err, 0);
        for (int i = 0; i < 4; i++) pop_one();
        check("t4_ready_after_drain", ready, 0);
        pulse_clear();
        check("t4_overrun_cleared", overrun, 0);

        // Push into a full FIFO on the same cycle as a pop edge.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 0, 0);
        end
        check("t5_full_no_overrun", overrun, 0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b0, 619, 0);
        repeat (4) @(negedge clk);
        check("t5_overrun_after_simul", overrun, 0);
        check("t5_ready", ready, 1);
        for (int i = 0; i < 4; i++) pop_one();
        check("t5_ready_after_drain", ready, 0);

        // Reset in the middle of a frame.
        send_frame(8'hF0, 1'b1, 1'b0, 0, 352);
        check("t6_reset_ready", ready, 0);
        check("t6_reset_data", {24'd0, data}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b1, 0, 0);
        pop_one();
        check("t6_ready_after_pop", ready, 0);
        check("t6_frame_err", frame_err, 0);
        check("t6_overrun", overrun, 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
